// File: rtl/dl_rr_arb8_if.sv
// Handshake bundle between the 8-way round-robin arbiter and its requesters/consumer.
// The master side is the arbiter; the slave side is the surrounding logic.
interface dl_rr_arb8_if;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic [7:0] ack;

    modport master (
        input  req,
        input  out_ready,
        output out_valid,
        output grant_idx,
        output grant_oh,
        output ack
    );

    modport slave (
        output req,
        output out_ready,
        input  out_valid,
        input  grant_idx,
        input  grant_oh,
        input  ack
    );
endinterface

// File: rtl/dl_rr_arb8.sv
// 8-requester round-robin arbiter with a registered grant and valid/ready release.
// Back-to-back grants: the next winner is picked in the handshake cycle itself.
module dl_rr_arb8 #(
    parameter logic [2:0] RESET_PTR    = 3'd0,
    parameter bit         HOLD_ON_DROP = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    dl_rr_arb8_if.master arb
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;

    logic       grant_v;
    logic       hs;
    logic       any_req;
    logic [2:0] idx_inc;
    logic [2:0] base;
    logic [2:0] pick;

    // First set bit scanning upward from b, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] b,
                                           input logic [7:0] r);
        logic [2:0] k;
        logic       found;
        rr_pick = b;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = b + 3'(i);
            if (!found && r[k]) begin
                rr_pick = k;
                found   = 1'b1;
            end
        end
    endfunction

    assign grant_v = (state_q == GRANT);
    assign hs      = grant_v & arb.out_ready;
    assign any_req = |arb.req;
    assign idx_inc = idx_q + 3'd1;
    assign base    = hs ? idx_inc : ptr_q;
    assign pick    = rr_pick(base, arb.req);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = pick;
                end
            end
            GRANT: begin
                if (hs) begin
                    ptr_d = idx_inc;
                    if (any_req) begin
                        idx_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!HOLD_ON_DROP && !arb.req[idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= RESET_PTR;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign arb.out_valid = grant_v;
    assign arb.grant_idx = idx_q;
    assign arb.grant_oh  = grant_v ? (8'd1 << idx_q) : 8'd0;
    assign arb.ack       = hs ? arb.grant_oh : 8'd0;

endmodule
